// File: rtl/e203_ifu_lockstep_ctrl_pkg.sv
// rtl/e203_ifu_lockstep_ctrl_pkg.sv - lockstep controller state encodings and shared types
package e203_ifu_lockstep_ctrl_pkg;

    typedef logic [2:0] ls_state_t;

    // Encodings are shared with the commit-stage logic, so keep the values fixed.
    localparam ls_state_t LS_IDLE  = 3'd0;
    localparam ls_state_t LS_SYNC  = 3'd1;
    localparam ls_state_t LS_CHECK = 3'd2;
    localparam ls_state_t LS_HALT  = 3'd3;
    localparam ls_state_t LS_FLUSH = 3'd4;
    localparam ls_state_t LS_FAIL  = 3'd5;

endpackage

// File: rtl/e203_ifu_lockstep_ctrl_if.sv
// rtl/e203_ifu_lockstep_ctrl_if.sv - master/redundant IFU bundles plus halt/flush handshake
interface e203_ifu_lockstep_ctrl_if #(
    parameter int PC_W = 32,
    parameter int IR_W = 32
);
    logic            m_valid;
    logic [PC_W-1:0] m_pc;
    logic [IR_W-1:0] m_ir;
    logic            m_cmd_valid;
    logic [PC_W-1:0] m_cmd_addr;
    logic            r_valid;
    logic [PC_W-1:0] r_pc;
    logic [IR_W-1:0] r_ir;
    logic            r_cmd_valid;
    logic [PC_W-1:0] r_cmd_addr;
    logic            m_halt_ack;
    logic            r_halt_ack;
    logic            ls_halt_req;
    logic            ls_flush_req;

    // Pipeline side: drives both IFU bundles and acks, receives halt/flush.
    modport master (
        output m_valid, m_pc, m_ir, m_cmd_valid, m_cmd_addr,
        output r_valid, r_pc, r_ir, r_cmd_valid, r_cmd_addr,
        output m_halt_ack, r_halt_ack,
        input  ls_halt_req, ls_flush_req
    );

    // Controller side.
    modport slave (
        input  m_valid, m_pc, m_ir, m_cmd_valid, m_cmd_addr,
        input  r_valid, r_pc, r_ir, r_cmd_valid, r_cmd_addr,
        input  m_halt_ack, r_halt_ack,
        output ls_halt_req, ls_flush_req
    );
endinterface

// File: rtl/e203_ls_dly_line.sv
// rtl/e203_ls_dly_line.sv - width/depth parameterised shift register with synchronous clear
module e203_ls_dly_line #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    // Shift one stage per cycle; a clear empties every stage including the incoming beat.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
        if (!clr) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/e203_ifu_lockstep_ctrl.sv
// rtl/e203_ifu_lockstep_ctrl.sv - lockstep compare of master vs redundant IFU with halt/flush recovery
module e203_ifu_lockstep_ctrl
    import e203_ifu_lockstep_ctrl_pkg::*;
#(
    parameter int DELAY     = 2,
    parameter int PC_W      = 32,
    parameter int IR_W      = 32,
    parameter int CNT_W     = 8,
    parameter int RETRY_MAX = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       chk_en,
    input  logic                       err_clr,
    e203_ifu_lockstep_ctrl_if.slave    ls_if,
    output logic                       ls_fatal,
    output logic [2:0]                 ls_state,
    output logic [CNT_W-1:0]           mismatch_cnt
);
    localparam int BW   = 2*PC_W + IR_W + 2;
    localparam int RC_W = $clog2(RETRY_MAX + 2);
    localparam int SC_W = $clog2(DELAY + 1);

    logic [BW-1:0]    dly_in, dly_out;
    logic             d_valid, d_cmd_valid;
    logic [PC_W-1:0]  d_pc, d_cmd_addr;
    logic [IR_W-1:0]  d_ir;
    logic             fetch_mis, cmd_mis, mismatch;

    ls_state_t        state_q, state_d;
    logic [SC_W-1:0]  sync_cnt_q, sync_cnt_d;
    logic [RC_W-1:0]  retry_cnt_q, retry_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
    logic             halt_req_q, halt_req_d;
    logic             flush_req_q, flush_req_d;
    logic             fatal_q, fatal_d;

    assign dly_in = {ls_if.m_valid, ls_if.m_pc, ls_if.m_ir, ls_if.m_cmd_valid, ls_if.m_cmd_addr};
    assign {d_valid, d_pc, d_ir, d_cmd_valid, d_cmd_addr} = dly_out;

    // The flush cycle wipes the delayed master history so both cores restart aligned.
    e203_ls_dly_line #(.W(BW), .DEPTH(DELAY)) u_dly_line (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush_req_q),
        .din  (dly_in),
        .dout (dly_out)
    );

    // Payload fields only matter when their valid is set on both sides.
    assign fetch_mis = (d_valid != ls_if.r_valid) ||
                       (d_valid && ls_if.r_valid && ((d_pc != ls_if.r_pc) || (d_ir != ls_if.r_ir)));
    assign cmd_mis   = (d_cmd_valid != ls_if.r_cmd_valid) ||
                       (d_cmd_valid && ls_if.r_cmd_valid && (d_cmd_addr != ls_if.r_cmd_addr));
    assign mismatch  = fetch_mis || cmd_mis;

    // Next-state, counters and registered Moore outputs.
    always_comb begin
        state_d     = state_q;
        sync_cnt_d  = sync_cnt_q;
        retry_cnt_d = retry_cnt_q;
        mis_cnt_d   = mis_cnt_q;
        case (state_q)
            LS_IDLE: begin
                if (chk_en) begin
                    state_d    = LS_SYNC;
                    sync_cnt_d = '0;
                end
            end
            LS_SYNC: begin
                if (sync_cnt_q == SC_W'(DELAY - 1)) state_d = LS_CHECK;
                else sync_cnt_d = sync_cnt_q + SC_W'(1);
            end
            LS_CHECK: begin
                if (mismatch) begin
                    if (mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + CNT_W'(1);
                    // A simultaneous err_clr resets the retry budget, so it cannot escalate.
                    state_d = (retry_cnt_q == RC_W'(RETRY_MAX) && !err_clr) ? LS_FAIL : LS_HALT;
                end else if (d_valid) begin
                    retry_cnt_d = '0;
                end
            end
            LS_HALT: begin
                if (ls_if.m_halt_ack && ls_if.r_halt_ack) state_d = LS_FLUSH;
            end
            LS_FLUSH: begin
                retry_cnt_d = retry_cnt_q + RC_W'(1);
                sync_cnt_d  = '0;
                state_d     = LS_SYNC;
            end
            LS_FAIL: begin
                if (err_clr) state_d = LS_IDLE;
            end
            default: state_d = LS_IDLE;
        endcase
        if (!chk_en && state_q != LS_FAIL) state_d = LS_IDLE;
        if (err_clr) begin
            mis_cnt_d   = '0;
            retry_cnt_d = '0;
        end
        halt_req_d  = (state_d == LS_HALT) || (state_d == LS_FAIL);
        flush_req_d = (state_d == LS_FLUSH);
        fatal_d     = (state_d == LS_FAIL);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LS_IDLE;
            sync_cnt_q  <= '0;
            retry_cnt_q <= '0;
            mis_cnt_q   <= '0;
            halt_req_q  <= 1'b0;
            flush_req_q <= 1'b0;
            fatal_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_cnt_q  <= sync_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            mis_cnt_q   <= mis_cnt_d;
            halt_req_q  <= halt_req_d;
            flush_req_q <= flush_req_d;
            fatal_q     <= fatal_d;
        end
    end

    assign ls_if.ls_halt_req  = halt_req_q;
    assign ls_if.ls_flush_req = flush_req_q;
    assign ls_fatal           = fatal_q;
    assign ls_state           = state_q;
    assign mismatch_cnt       = mis_cnt_q;

endmodule

// File: tb/tb_e203_ifu_lockstep_ctrl.sv
// tb/tb_e203_ifu_lockstep_ctrl.sv - directed self-checking bench for the IFU lockstep controller
module tb_e203_ifu_lockstep_ctrl;
    import e203_ifu_lockstep_ctrl_pkg::*;

    localparam logic [31:0] P0 = 32'h8000_0000;
    localparam logic [31:0] I0 = 32'h0000_0513;

    logic clk = 1'b0;
    logic rst, chk_en, err_clr;
    always #5 clk = ~clk;

    e203_ifu_lockstep_ctrl_if #(.PC_W(32), .IR_W(32)) ifa ();
    e203_ifu_lockstep_ctrl_if #(.PC_W(32), .IR_W(32)) ifb ();

    assign ifb.m_valid     = ifa.m_valid;
    assign ifb.m_pc        = ifa.m_pc;
    assign ifb.m_ir        = ifa.m_ir;
    assign ifb.m_cmd_valid = ifa.m_cmd_valid;
    assign ifb.m_cmd_addr  = ifa.m_cmd_addr;
    assign ifb.r_valid     = ifa.r_valid;
    assign ifb.r_pc        = ifa.r_pc;
    assign ifb.r_ir        = ifa.r_ir;
    assign ifb.r_cmd_valid = ifa.r_cmd_valid;
    assign ifb.r_cmd_addr  = ifa.r_cmd_addr;
    assign ifb.m_halt_ack  = ifa.m_halt_ack;
    assign ifb.r_halt_ack  = ifa.r_halt_ack;

    logic       fatal_a, fatal_b;
    logic [2:0] st_a, st_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    e203_ifu_lockstep_ctrl #(.DELAY(2), .CNT_W(8), .RETRY_MAX(3)) dut_a (
        .clk(clk), .rst(rst), .chk_en(chk_en), .err_clr(err_clr), .ls_if(ifa),
        .ls_fatal(fatal_a), .ls_state(st_a), .mismatch_cnt(cnt_a)
    );

    e203_ifu_lockstep_ctrl #(.DELAY(2), .CNT_W(2), .RETRY_MAX(3)) dut_b (
        .clk(clk), .rst(rst), .chk_en(chk_en), .err_clr(err_clr), .ls_if(ifb),
        .ls_fatal(fatal_b), .ls_state(st_b), .mismatch_cnt(cnt_b)
    );

    typedef struct packed {
        logic v; logic [31:0] pc; logic [31:0] ir; logic cv; logic [31:0] ca;
    } beat_t;

    typedef struct {
        beat_t m;
        beat_t r;
        logic  exp_mis;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    bit    stream_on;
    logic [31:0] pc_n;
    beat_t h0, h1;
    vec_t  vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_m(input beat_t b);
        ifa.m_valid = b.v; ifa.m_pc = b.pc; ifa.m_ir = b.ir; ifa.m_cmd_valid = b.cv; ifa.m_cmd_addr = b.ca;
    endtask

    task automatic set_r(input beat_t b);
        ifa.r_valid = b.v; ifa.r_pc = b.pc; ifa.r_ir = b.ir; ifa.r_cmd_valid = b.cv; ifa.r_cmd_addr = b.ca;
    endtask

    // Advance one clock; outputs are then stable and the next cycle's stream beat is driven.
    task automatic tick();
        beat_t b;
        @(posedge clk);
        #1;
        if (stream_on) begin
            b.v = 1'b1; b.pc = pc_n; b.ir = pc_n ^ 32'h1357_9bdf; b.cv = 1'b1; b.ca = pc_n;
            pc_n += 32'd4;
            set_m(b);
            set_r(h1);
            h1 = h0;
            h0 = b;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; chk_en = 1'b0; err_clr = 1'b0; stream_on = 1'b0;
        pc_n = P0; h0 = '0; h1 = '0;
        set_m('0); set_r('0);
        ifa.m_halt_ack = 1'b0; ifa.r_halt_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Start a clean lagging stream and run into CHECK.
    task automatic start_stream();
        do_reset();
        chk_en = 1'b1;
        stream_on = 1'b1;
        repeat (6) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int halts;

        vecs[0] = '{m: '{1, P0, I0, 1, P0},      r: '{1, P0, I0, 1, P0},                    exp_mis: 0};
        vecs[1] = '{m: '{0, P0, I0, 0, P0},      r: '{0, P0+4, I0^32'h1, 0, P0+8},          exp_mis: 0};
        vecs[2] = '{m: '{1, P0, I0, 1, P0},      r: '{0, P0, I0, 1, P0},                    exp_mis: 1};
        vecs[3] = '{m: '{1, P0, I0, 1, P0},      r: '{1, P0, I0^32'h1, 1, P0},              exp_mis: 1};
        vecs[4] = '{m: '{1, P0, I0, 1, P0},      r: '{1, P0+4, I0, 1, P0},                  exp_mis: 1};
        vecs[5] = '{m: '{1, P0, I0, 1, P0},      r: '{1, P0, I0, 1, P0+4},                  exp_mis: 1};
        vecs[6] = '{m: '{1, P0, I0, 0, P0},      r: '{1, P0, I0, 1, P0},                    exp_mis: 1};
        vecs[7] = '{m: '{0, P0, I0, 1, P0},      r: '{0, P0+4, I0^32'h1, 1, P0},            exp_mis: 0};
        vecs[8] = '{m: '{1, P0, I0, 0, P0},      r: '{1, P0, I0, 0, P0+12},                 exp_mis: 0};

        // Reset values, then a long matching stream.
        do_reset();
        chk("rst_state", st_a, LS_IDLE);
        chk("rst_halt", ifa.ls_halt_req, 0);
        chk("rst_flush", ifa.ls_flush_req, 0);
        chk("rst_fatal", fatal_a, 0);
        chk("rst_cnt", cnt_a, 0);
        chk_en = 1'b1;
        stream_on = 1'b1;
        halts = 0;
        repeat (100) begin
            tick();
            if (ifa.ls_halt_req) halts++;
        end
        chk("t1_halts", halts, 0);
        chk("t1_state", st_a, LS_CHECK);
        chk("t1_cnt", cnt_a, 0);

        // Acks outside HALT have no effect.
        ifa.m_halt_ack = 1'b1; ifa.r_halt_ack = 1'b1;
        tick();
        chk("ack_idle_state", st_a, LS_CHECK);
        ifa.m_halt_ack = 1'b0; ifa.r_halt_ack = 1'b0;

        // Single corrupted beat, recovery and return to CHECK.
        ifa.r_ir[0] = ~ifa.r_ir[0];
        tick();
        chk("t2_halt", ifa.ls_halt_req, 1);
        chk("t2_state_halt", st_a, LS_HALT);
        chk("t2_cnt", cnt_a, 1);
        ifa.m_halt_ack = 1'b1; ifa.r_halt_ack = 1'b1;
        tick();
        chk("t2_state_flush", st_a, LS_FLUSH);
        chk("t2_flush", ifa.ls_flush_req, 1);
        chk("t2_halt_in_flush", ifa.ls_halt_req, 0);
        ifa.m_halt_ack = 1'b0; ifa.r_halt_ack = 1'b0;
        tick();
        chk("t2_flush_drop", ifa.ls_flush_req, 0);
        chk("t2_state_sync", st_a, LS_SYNC);
        tick();
        tick();
        chk("t2_state_check", st_a, LS_CHECK);
        halts = 0;
        repeat (20) begin
            tick();
            if (ifa.ls_halt_req) halts++;
        end
        chk("t2_resync_halts", halts, 0);

        // err_clr together with a mismatch: counters clear, still halts.
        ifa.r_ir[0] = ~ifa.r_ir[0];
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_mis_state", st_a, LS_HALT);
        chk("clr_mis_cnt", cnt_a, 0);

        // Back-to-back failed recoveries escalate on the fourth mismatch.
        start_stream();
        for (int i = 0; i < 4; i++) begin
            ifa.r_ir[0] = ~ifa.r_ir[0];
            tick();
            if (i < 3) begin
                chk($sformatf("t3_halt_%0d", i), st_a, LS_HALT);
                ifa.m_halt_ack = 1'b1; ifa.r_halt_ack = 1'b1;
                tick();
                ifa.m_halt_ack = 1'b0; ifa.r_halt_ack = 1'b0;
                repeat (3) tick();
                chk($sformatf("t3_check_%0d", i), st_a, LS_CHECK);
            end
        end
        chk("t3_state_fail", st_a, LS_FAIL);
        chk("t3_fatal", fatal_a, 1);
        chk("t3_halt", ifa.ls_halt_req, 1);
        chk("t3_cnt", cnt_a, 4);
        chk("t3_cnt_sat", cnt_b, 3);
        chk("t3_b_state", st_b, LS_FAIL);
        chk_en = 1'b0;
        tick();
        tick();
        chk("t3_fail_sticky", st_a, LS_FAIL);
        chk_en = 1'b1;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_clr_state", st_a, LS_IDLE);
        chk("t3_clr_cnt", cnt_a, 0);
        chk("t3_clr_fatal", fatal_a, 0);
        chk("t3_clr_halt", ifa.ls_halt_req, 0);

        // Acks must coincide.
        start_stream();
        ifa.r_ir[0] = ~ifa.r_ir[0];
        tick();
        chk("t4_halt", st_a, LS_HALT);
        ifa.m_halt_ack = 1'b1;
        tick();
        chk("t4_m_only", st_a, LS_HALT);
        ifa.m_halt_ack = 1'b0; ifa.r_halt_ack = 1'b1;
        tick();
        chk("t4_r_only", st_a, LS_HALT);
        ifa.r_halt_ack = 1'b0;
        tick();
        chk("t4_none", st_a, LS_HALT);
        ifa.m_halt_ack = 1'b1; ifa.r_halt_ack = 1'b1;
        tick();
        chk("t4_both", st_a, LS_FLUSH);
        ifa.m_halt_ack = 1'b0; ifa.r_halt_ack = 1'b0;

        // Asynchronous reset in HALT.
        start_stream();
        ifa.r_ir[0] = ~ifa.r_ir[0];
        tick();
        chk("t6_pre_halt", ifa.ls_halt_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_arst_halt", ifa.ls_halt_req, 0);
        chk("t6_arst_state", st_a, LS_IDLE);
        chk("t6_arst_cnt", cnt_a, 0);
        #1 rst = 1'b0;

        // Dropping chk_en in HALT.
        start_stream();
        ifa.r_ir[0] = ~ifa.r_ir[0];
        tick();
        chk("t6_halt2", st_a, LS_HALT);
        chk_en = 1'b0;
        tick();
        chk("t6_chken_state", st_a, LS_IDLE);
        chk("t6_chken_halt", ifa.ls_halt_req, 0);

        // Comparator vectors: master beat in cycle 3, redundant beat in cycle 5.
        for (int k = 0; k < 9; k++) begin
            do_reset();
            chk_en = 1'b1;
            repeat (3) tick();
            set_m(vecs[k].m);
            tick();
            set_m('0);
            tick();
            set_r(vecs[k].r);
            tick();
            chk($sformatf("vec%0d_halt", k), ifa.ls_halt_req, vecs[k].exp_mis);
            chk($sformatf("vec%0d_cnt", k), cnt_a, vecs[k].exp_mis);
            chk($sformatf("vec%0d_state", k), st_a, vecs[k].exp_mis ? LS_HALT : LS_CHECK);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
